// File: rtl/peripheral_dbg_pu_riscv_pkg.sv
// Shared limits and helpers for the debug-unit event synchroniser.
package peripheral_dbg_pu_riscv_pkg;

    localparam int unsigned SyncStagesMin = 2;
    localparam int unsigned SyncStagesMax = 4;
    localparam int unsigned ChannelsMin   = 1;
    localparam int unsigned ChannelsMax   = 32;

    // Width of the channel index; at least one bit even for a single channel.
    function automatic int unsigned sel_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/peripheral_dbg_pu_riscv_sync_event_if.sv
// Event-side bus of the synchroniser: event inputs, per-channel status and the priority result.
import peripheral_dbg_pu_riscv_pkg::*;

interface peripheral_dbg_pu_riscv_sync_event_if #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 3,
    parameter int unsigned SEL_W     = sel_width(CHANNELS)
);
    logic [CHANNELS-1:0]           toggle_in;
    logic [CHANNELS-1:0]           set;
    logic [CHANNELS-1:0]           ack;
    logic [CHANNELS-1:0]           clr;
    logic [CHANNELS-1:0]           d_out;
    logic [CHANNELS*CNT_WIDTH-1:0] count;
    logic [CHANNELS-1:0]           ovf;
    logic                          any;
    logic [SEL_W-1:0]              sel;

    modport master (
        output toggle_in, set, ack, clr,
        input  d_out, count, ovf, any, sel
    );

    modport slave (
        input  toggle_in, set, ack, clr,
        output d_out, count, ovf, any, sel
    );
endinterface

// File: rtl/peripheral_dbg_pu_riscv_sync_event_ch.sv
// One event channel: toggle synchroniser, edge detect, saturating pending counter and sticky overflow.
import peripheral_dbg_pu_riscv_pkg::*;

module peripheral_dbg_pu_riscv_sync_event_ch #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 3
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 primed_i,
    input  logic                 toggle_i,
    input  logic                 set_i,
    input  logic                 ack_i,
    input  logic                 clr_i,
    output logic                 d_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 ovf_o
);
    localparam logic [CNT_WIDTH+1:0] CntMax = {2'b00, {CNT_WIDTH{1'b1}}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   tog;
    logic [1:0]             inc;
    logic                   dec;
    logic [CNT_WIDTH+1:0]   sum;

    // Until primed, prev tracks the chain so a level held through reset is the baseline.
    assign tog = (sync_q[SYNC_STAGES-1] ^ prev_q) & primed_i;

    always_comb begin
        inc     = {1'b0, tog} + {1'b0, set_i};
        dec     = ack_i & ((count_q != '0) | (inc != 2'd0));
        sum     = {2'b00, count_q} + {{CNT_WIDTH{1'b0}}, inc} - {{(CNT_WIDTH+1){1'b0}}, dec};
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (sum > CntMax) begin
            count_d = '1;
            ovf_d   = 1'b1;
        end else begin
            count_d = sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], toggle_i};
            prev_q  <= sync_q[SYNC_STAGES-1];
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Fast path: an event is visible in the cycle it is detected.
    assign d_o     = (count_q != '0) | tog | set_i;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/peripheral_dbg_pu_riscv_sync_event.sv
// Multi-channel toggle-event synchroniser: priming counter, per-channel instances, ANY and SEL.
import peripheral_dbg_pu_riscv_pkg::*;

module peripheral_dbg_pu_riscv_sync_event #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 3
) (
    input logic                                 clk_i,
    input logic                                 rstn_i,
    peripheral_dbg_pu_riscv_sync_event_if.slave bus
);
    localparam int unsigned SelW        = sel_width(CHANNELS);
    localparam logic [2:0]  PrimeCycles = 3'(SYNC_STAGES + 1);

    logic [2:0]                    prime_cnt_q;
    logic                          primed;
    logic [CHANNELS-1:0]           d_out;
    logic [CHANNELS-1:0]           ovf;
    logic [CHANNELS*CNT_WIDTH-1:0] count;
    logic [SelW-1:0]               sel;

    assign primed = (prime_cnt_q == PrimeCycles);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            prime_cnt_q <= '0;
        end else if (!primed) begin
            prime_cnt_q <= prime_cnt_q + 3'd1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
        peripheral_dbg_pu_riscv_sync_event_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_ch (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .primed_i (primed),
            .toggle_i (bus.toggle_in[g]),
            .set_i    (bus.set[g]),
            .ack_i    (bus.ack[g]),
            .clr_i    (bus.clr[g]),
            .d_o      (d_out[g]),
            .count_o  (count[g*CNT_WIDTH +: CNT_WIDTH]),
            .ovf_o    (ovf[g])
        );
    end

    // Walk downwards so the lowest pending index wins.
    always_comb begin
        sel = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (d_out[i]) sel = SelW'(i);
        end
    end

    assign bus.d_out = d_out;
    assign bus.count = count;
    assign bus.ovf   = ovf;
    assign bus.any   = |d_out;
    assign bus.sel   = sel;

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_sync_event.sv
// Directed self-checking bench for the multi-channel toggle-event synchroniser.
import peripheral_dbg_pu_riscv_pkg::*;

module tb_peripheral_dbg_pu_riscv_sync_event;

    localparam int unsigned CH = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned CW = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    peripheral_dbg_pu_riscv_sync_event_if #(.CHANNELS(CH), .CNT_WIDTH(CW), .SEL_W(2)) bus ();

    peripheral_dbg_pu_riscv_sync_event #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SS),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] cnt(input int ch);
        return bus.count[ch*CW +: CW];
    endfunction

    task automatic test_reset();
        bus.toggle_in = 4'b1010;
        bus.set = '0;
        bus.ack = '0;
        bus.clr = '0;
        rstn = 1'b0;
        repeat (3) step();
        #1;
        checks++;
        if (bus.d_out !== 4'b0000) begin
            errors++; $display("FAIL reset_d_out got %b want 0000", bus.d_out);
        end
        checks++;
        if (bus.count !== 12'h000) begin
            errors++; $display("FAIL reset_count got %h want 000", bus.count);
        end
        checks++;
        if (bus.ovf !== 4'b0000 || bus.any !== 1'b0 || bus.sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_flags got ovf=%b any=%b sel=%0d want 0 0 0", bus.ovf, bus.any,
                     bus.sel);
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.d_out !== 4'b0000 || bus.count !== 12'h000) begin
                errors++;
                $display("FAIL prime_baseline cyc %0d got d=%b cnt=%h want 0 0", i, bus.d_out,
                         bus.count);
            end
        end
    endtask

    task automatic test_single_toggle();
        bus.toggle_in[2] = ~bus.toggle_in[2];
        step();
        checks++;
        if (bus.d_out[2] !== 1'b0) begin
            errors++; $display("FAIL tog2_early got %b want 0", bus.d_out[2]);
        end
        step();
        checks++;
        if (bus.d_out !== 4'b0100 || bus.sel !== 2'd2 || bus.any !== 1'b1 || cnt(2) !== 3'd0) begin
            errors++;
            $display("FAIL tog2_detect got d=%b sel=%0d any=%b cnt=%0d want 0100 2 1 0",
                     bus.d_out, bus.sel, bus.any, cnt(2));
        end
        step();
        checks++;
        if (cnt(2) !== 3'd1 || bus.d_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL tog2_count got cnt=%0d d=%b want 1 1", cnt(2), bus.d_out[2]);
        end
        bus.ack[2] = 1'b1;
        step();
        bus.ack[2] = 1'b0;
        checks++;
        if (cnt(2) !== 3'd0 || bus.d_out !== 4'b0000) begin
            errors++;
            $display("FAIL tog2_ack got cnt=%0d d=%b want 0 0000", cnt(2), bus.d_out);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            bus.toggle_in[0] = ~bus.toggle_in[0];
            repeat (SS + 1) step();
            if (i == 6) begin
                checks++;
                if (cnt(0) !== 3'd7 || bus.ovf[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_at_max got cnt=%0d ovf=%b want 7 0", cnt(0), bus.ovf[0]);
                end
            end
        end
        checks++;
        if (cnt(0) !== 3'd7 || bus.ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sat got cnt=%0d ovf=%b want 7 1", cnt(0), bus.ovf[0]);
        end
        bus.clr[0] = 1'b1;
        step();
        bus.clr[0] = 1'b0;
        checks++;
        if (cnt(0) !== 3'd0 || bus.ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr got cnt=%0d ovf=%b want 0 0", cnt(0), bus.ovf[0]);
        end
    endtask

    task automatic test_combined();
        bus.set[1] = 1'b1;
        repeat (3) step();
        bus.set[1] = 1'b0;
        checks++;
        if (cnt(1) !== 3'd3) begin
            errors++; $display("FAIL comb_preload got %0d want 3", cnt(1));
        end
        bus.toggle_in[1] = ~bus.toggle_in[1];
        repeat (SS) step();
        bus.set[1] = 1'b1;
        bus.ack[1] = 1'b1;
        step();
        bus.set[1] = 1'b0;
        bus.ack[1] = 1'b0;
        checks++;
        if (cnt(1) !== 3'd4) begin
            errors++; $display("FAIL comb_tog_set_ack got %0d want 4", cnt(1));
        end
        bus.toggle_in[1] = ~bus.toggle_in[1];
        repeat (SS) step();
        bus.clr[1] = 1'b1;
        bus.set[1] = 1'b1;
        step();
        bus.clr[1] = 1'b0;
        bus.set[1] = 1'b0;
        checks++;
        if (cnt(1) !== 3'd0 || bus.ovf[1] !== 1'b0) begin
            errors++;
            $display("FAIL comb_clr got cnt=%0d ovf=%b want 0 0", cnt(1), bus.ovf[1]);
        end
        step();
        checks++;
        if (cnt(1) !== 3'd0 || bus.d_out[1] !== 1'b0) begin
            errors++;
            $display("FAIL comb_clr_hold got cnt=%0d d=%b want 0 0", cnt(1), bus.d_out[1]);
        end
    endtask

    task automatic test_sel();
        bus.set = 4'b1010;
        repeat (2) step();
        bus.set = 4'b0000;
        checks++;
        if (bus.sel !== 2'd1 || cnt(1) !== 3'd2 || cnt(3) !== 3'd2) begin
            errors++;
            $display("FAIL sel_two got sel=%0d c1=%0d c3=%0d want 1 2 2", bus.sel, cnt(1), cnt(3));
        end
        bus.ack[1] = 1'b1;
        step();
        checks++;
        if (bus.sel !== 2'd1 || cnt(1) !== 3'd1) begin
            errors++; $display("FAIL sel_ack1 got sel=%0d c1=%0d want 1 1", bus.sel, cnt(1));
        end
        step();
        checks++;
        if (bus.sel !== 2'd3 || cnt(1) !== 3'd0) begin
            errors++; $display("FAIL sel_ack2 got sel=%0d c1=%0d want 3 0", bus.sel, cnt(1));
        end
        step();
        bus.ack[1] = 1'b0;
        checks++;
        if (cnt(1) !== 3'd0 || bus.ovf[1] !== 1'b0 || bus.sel !== 2'd3) begin
            errors++;
            $display("FAIL sel_ack_empty got c1=%0d ovf=%b sel=%0d want 0 0 3", cnt(1),
                     bus.ovf[1], bus.sel);
        end
        bus.clr[3] = 1'b1;
        step();
        bus.clr[3] = 1'b0;
        checks++;
        if (bus.any !== 1'b0 || bus.sel !== 2'd0) begin
            errors++; $display("FAIL sel_idle got any=%b sel=%0d want 0 0", bus.any, bus.sel);
        end
    endtask

    task automatic test_reset_mid();
        bus.set = 4'b1111;
        repeat (5) step();
        bus.set = 4'b0000;
        checks++;
        if (bus.count !== 12'hB6D) begin
            errors++; $display("FAIL mid_preload got %h want b6d", bus.count);
        end
        rstn = 1'b0;
        bus.toggle_in[0] = ~bus.toggle_in[0];
        step();
        checks++;
        if (bus.d_out !== 4'b0000 || bus.count !== 12'h000 || bus.ovf !== 4'b0000 ||
            bus.any !== 1'b0 || bus.sel !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset got d=%b cnt=%h ovf=%b any=%b sel=%0d want all 0",
                     bus.d_out, bus.count, bus.ovf, bus.any, bus.sel);
        end
        step();
        rstn = 1'b1;
        bus.toggle_in[2] = ~bus.toggle_in[2];
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.d_out !== 4'b0000 || bus.count !== 12'h000) begin
                errors++;
                $display("FAIL mid_reprime cyc %0d got d=%b cnt=%h want 0 0", i, bus.d_out,
                         bus.count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_toggle();
        test_overflow();
        test_combined();
        test_sel();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
